adder_sum_normalizer: RTL and testbench

ADDER_SUM_NORMALIZER -- requirements
Module: adder_sum_normalizer

---
 rtl/adder_sum_normalizer.sv | 137 +++++++++++++
 tb/tb_adder_sum_normalizer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_normalizer.sv
// FP32 aligned-mantissa add/subtract with normalize and pack, two-stage valid/ready pipeline.
// Optional sticky overflow/underflow flags are enabled by defining ADDER_SUM_STICKY_FLAGS_EN.
module adder_sum_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_big,
  input  logic        sign_little,
  input  logic [7:0]  exp_in,
  input  logic [22:0] mant_big,
  input  logic [22:0] mant_little,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
`ifdef ADDER_SUM_STICKY_FLAGS_EN
  ,
  input  logic        flag_clr,
  output logic        ovf_flag,
  output logic        unf_flag
`endif
);

  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [23:0] s1_mag;
  logic        s2_valid;
  logic        s2_advance;
  logic        s2_ovf;
  logic        s2_unf;

  logic [23:0] sum_w;
  logic [23:0] diff_w;
  logic [23:0] mag_in;
  logic        sign_in;

  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign out_valid  = s2_valid;

  // Both mantissas are below 2^23, so bit 23 of the difference is its sign.
  assign sum_w   = {1'b0, mant_big} + {1'b0, mant_little};
  assign diff_w  = {1'b0, mant_big} - {1'b0, mant_little};
  assign mag_in  = (sign_big == sign_little) ? sum_w : (diff_w[23] ? -diff_w : diff_w);
  assign sign_in = (sign_big != sign_little && diff_w[23]) ? sign_little : sign_big;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= 8'h00;
      s1_mag   <= 24'h000000;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sign_in;
        s1_exp  <= exp_in;
        s1_mag  <= mag_in;
      end
    end
  end

  logic [4:0]        lz;
  logic              found;
  logic [22:0]       shl;
  logic signed [9:0] exp_n;
  logic              is_zero;
  logic              unf_c;
  logic              ovf_c;
  logic [21:0]       frac_c;
  logic [31:0]       pack_c;

  always_comb begin
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!found) begin
        if (s1_mag[i]) found = 1'b1;
        else           lz    = lz + 5'd1;
      end
    end
  end

  // shl[22] is set exactly when the low 23 bits are non-zero, so it doubles as the zero test.
  assign shl     = s1_mag[22:0] << lz;
  assign is_zero = !s1_mag[23] && !shl[22];
  assign exp_n   = s1_mag[23] ? ($signed({2'b00, s1_exp}) + 10'sd1)
                              : ($signed({2'b00, s1_exp}) - $signed({5'b00000, lz}));
  assign frac_c  = s1_mag[23] ? s1_mag[22:1] : shl[21:0];
  assign unf_c   = !is_zero && (exp_n <= 10'sd0);
  assign ovf_c   = !is_zero && !unf_c && (exp_n >= 10'sd255);

  always_comb begin
    pack_c = {s1_sign, exp_n[7:0], frac_c, 1'b0};
    if (is_zero)    pack_c = 32'h00000000;
    else if (unf_c) pack_c = {s1_sign, 31'b0};
    else if (ovf_c) pack_c = {s1_sign, 8'hFF, 23'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= 32'h00000000;
      s2_ovf   <= 1'b0;
      s2_unf   <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= pack_c;
        s2_ovf <= ovf_c;
        s2_unf <= unf_c;
      end
    end
  end

`ifdef ADDER_SUM_STICKY_FLAGS_EN
  logic out_xfer;
  assign out_xfer = s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      if (out_xfer && s2_ovf) ovf_flag <= 1'b1;
      else if (flag_clr)      ovf_flag <= 1'b0;
      if (out_xfer && s2_unf) unf_flag <= 1'b1;
      else if (flag_clr)      unf_flag <= 1'b0;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = s2_ovf ^ s2_unf;
`endif

endmodule

// File: tb/tb_adder_sum_normalizer.sv
// Randomized scoreboard bench for adder_sum_normalizer with directed corner vectors.
module tb_adder_sum_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_big;
  logic        sign_little;
  logic [7:0]  exp_in;
  logic [22:0] mant_big;
  logic [22:0] mant_little;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
`ifdef ADDER_SUM_STICKY_FLAGS_EN
  logic        flag_clr;
  logic        ovf_flag;
  logic        unf_flag;
`endif

  always #5 clk = ~clk;

  adder_sum_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_big(sign_big), .sign_little(sign_little), .exp_in(exp_in),
    .mant_big(mant_big), .mant_little(mant_little),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef ADDER_SUM_STICKY_FLAGS_EN
    , .flag_clr(flag_clr), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
`endif
  );

  typedef struct {
    logic [31:0] res;
    int          edge_n;
    bit          lat;
  } item_t;

  item_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int or_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: 0 = always ready, 1 = random backpressure, 2 = stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference: real sign/magnitude arithmetic, then locate the top set bit.
  function automatic logic [31:0] model(bit sb, bit sl, int e, int a, int b);
    int mag, p, ne, m;
    bit s;
    s = sb;
    if (sb == sl) mag = a + b;
    else begin
      mag = a - b;
      if (mag < 0) begin
        mag = -mag;
        s = sl;
      end
    end
    if (mag == 0) return 32'h00000000;
    p = 23;
    while (((mag >> p) & 1) == 0) p--;
    ne = e + p - 22;
    m  = (p == 23) ? (mag >> 1) : (mag << (22 - p));
    if (ne <= 0)   return {s, 31'b0};
    if (ne >= 255) return {s, 8'hFF, 23'b0};
    return {s, ne[7:0], m[21:0], 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected no output", result);
      end else begin
        item_t it;
        it = sb_q.pop_front();
        chk("result", result, it.res);
        if (it.lat) chk("latency", 32'(cyc + 1 - it.edge_n), 32'd2);
      end
    end
  end

  task automatic send(input logic sb, input logic sl, input logic [7:0] e,
                      input logic [22:0] a, input logic [22:0] b,
                      input logic [31:0] exp_res, output int stalls);
    item_t it;
    sign_big = sb; sign_little = sl; exp_in = e; mant_big = a; mant_little = b;
    in_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls <= 200) begin
      stalls++;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    it.res = exp_res; it.edge_n = cyc + 1; it.lat = (or_mode == 0);
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_operand(output logic sb, output logic sl, output logic [7:0] e,
                              output logic [22:0] a, output logic [22:0] b);
    sb = 1'($urandom); sl = 1'($urandom);
    case ($urandom_range(0, 6))
      0: e = 8'd0;
      1: e = 8'd1;
      2: e = 8'd2;
      3: e = 8'd253;
      4: e = 8'd254;
      5: e = 8'd255;
      default: e = 8'($urandom);
    endcase
    a = {($urandom_range(0, 7) != 0), 22'($urandom)};
    b = 23'($urandom) >> $urandom_range(0, 24);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st, acc;
    logic sb, sl;
    logic [7:0] e;
    logic [22:0] a, b;

    rst_n = 1'b0; in_valid = 1'b0; sign_big = 1'b0; sign_little = 1'b0;
    exp_in = 8'h00; mant_big = 23'h0; mant_little = 23'h0;
`ifdef ADDER_SUM_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_result", result, 32'h00000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(1'b0, 1'b0, 8'h7F, 23'h600000, 23'h600000, 32'h40400000, st);
    chk("first_accept_stalls", 32'(st), 32'd0);
    send(1'b0, 1'b1, 8'h7F, 23'h600000, 23'h600000, 32'h00000000, st);
    send(1'b0, 1'b1, 8'h80, 23'h400000, 23'h300000, 32'h3F000000, st);
    send(1'b0, 1'b0, 8'hFE, 23'h7FFFFE, 23'h7FFFFE, 32'h7F800000, st);
    drain();
`ifdef ADDER_SUM_STICKY_FLAGS_EN
    chk("ovf_flag_set", {31'b0, ovf_flag}, 32'd1);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("ovf_flag_clr", {31'b0, ovf_flag}, 32'd0);
`endif
    // Difference of 1 at exponent 1 normalizes far below the smallest exponent.
    send(1'b1, 1'b0, 8'h01, 23'h400000, 23'h3FFFFF, 32'h80000000, st);
    send(1'b1, 1'b1, 8'hFF, 23'h400000, 23'h000000, 32'hFF800000, st);
    send(1'b0, 1'b1, 8'h80, 23'h300000, 23'h400000, 32'h3F000000 | 32'h80000000, st);
    drain();
`ifdef ADDER_SUM_STICKY_FLAGS_EN
    chk("unf_flag_set", {31'b0, unf_flag}, 32'd1);
`endif

    // Stalled consumer: only two operand sets fit.
    or_mode = 2;
    @(posedge clk);
    #1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      rand_operand(sb, sl, e, a, b);
      sign_big = sb; sign_little = sl; exp_in = e; mant_big = a; mant_little = b;
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        item_t it;
        it.res = model(sb, sl, int'(e), int'(a), int'(b)); it.edge_n = cyc + 1; it.lat = 1'b0;
        sb_q.push_back(it);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stall_accept_count", 32'(acc), 32'd2);
    @(negedge clk);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    or_mode = 0;
    drain();

    // Reset with two results in flight.
    or_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rand_operand(sb, sl, e, a, b);
      send(sb, sl, e, a, b, model(sb, sl, int'(e), int'(a), int'(b)), st);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    sb_q.delete();
    or_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send(1'b0, 1'b0, 8'h7F, 23'h600000, 23'h600000, 32'h40400000, st);
    chk("post_rst_accept_stalls", 32'(st), 32'd0);
    drain();

    // Randomized traffic with random backpressure and gaps.
    or_mode = 1;
    for (int i = 0; i < 300; i++) begin
      rand_operand(sb, sl, e, a, b);
      send(sb, sl, e, a, b, model(sb, sl, int'(e), int'(a), int'(b)), st);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    or_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
